rx_transmitter_fsm: RTL and testbench

- Transmit-side state machine for the 5-bit valid/ready link consumed by the receiver state block.
- Accepts one word from local logic and holds it stable with valid_o asserted until the receiver signals ready.
- Reports completion and keeps a wrapping sent-word count.
- Drives the shared 2-bit state encoding so the receiver side can sample it directly.

---
 rtl/rx_transmitter_fsm.sv | 165 ++++++++++++++++
 tb/tb_rx_transmitter_fsm.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_transmitter_fsm.sv
// ---------------------------------------------------------------------------
// rx_transmitter_fsm
//
// Transmit-side state machine for the 5-bit valid/ready link that feeds the
// receiver state block. A word is captured from local logic when start_i is
// seen in IDLE, presented for one LOAD cycle, then offered with valid_o until
// the receiver raises ready_i. A one-cycle DONE state reports completion.
//
// State encoding (shared with the receiver side, sampled directly):
//   IDLE = 2'b00, LOAD = 2'b01, VALID = 2'b10, DONE = 2'b11
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset
//   start_i    in   1       send request, sampled only in IDLE
//   data_i     in   DATA_W  word to send, captured with an accepted start_i
//   ready_i    in   1       receiver acceptance, meaningful only in VALID
//   busy_o     out  1       high in every state except IDLE
//   valid_o    out  1       data_o is offered to the receiver
//   data_o     out  DATA_W  captured word (kept until the next capture)
//   state_o    out  2       current state
//   done_o     out  1       one-cycle pulse in DONE
//   timeout_o  out  1       one-cycle pulse in DONE after an abandoned wait
//   tx_count_o out  CNT_W   successful handshakes, wrapping
//
// Optional feature (macro RX_TX_TIMEOUT_EN):
//   When defined, a wait counter abandons the VALID state after
//   TIMEOUT_CYCLES cycles without ready_i (legal range 1..255). A handshake
//   in the expiry cycle still wins. When undefined, VALID waits forever and
//   timeout_o is tied low. The port list is the same in both builds.
//
// Every output is either a register or a decode of the registered state, so
// there is no combinational path from start_i or ready_i to any output.
// ---------------------------------------------------------------------------
module rx_transmitter_fsm #(
    parameter int DATA_W         = 5,
    parameter int CNT_W          = 8,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              ready_i,
    output logic              busy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        state_o,
    output logic              done_o,
    output logic              timeout_o,
    output logic [CNT_W-1:0]  tx_count_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        VALID = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  data_q;
    logic [CNT_W-1:0]   count_q;
    logic               capture;
    logic               handshake;
    logic               wait_expired;

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    // NOTE: every signal driven here gets a default before the case so that no
    // path leaves it unassigned; otherwise a latch would be inferred.
    always_comb begin
        state_d   = state_q;
        capture   = 1'b0;
        handshake = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    capture = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: state_d = VALID;
            VALID: begin
                // A handshake takes priority over an expiring wait.
                if (ready_i) begin
                    handshake = 1'b1;
                    state_d   = DONE;
                end else if (wait_expired) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State, hold register and handshake counter
    // -----------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                data_q <= data_i;
            end
            if (handshake) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

`ifdef RX_TX_TIMEOUT_EN
    // -----------------------------------------------------------------------
    // VALID wait limit. The counter is held at zero outside VALID, which
    // gives a clean start on every entry. It counts cycles already spent
    // without ready_i, so the Nth VALID cycle sees N-1.
    // -----------------------------------------------------------------------
    logic [7:0] wait_q;
    logic       timeout_q;

    assign wait_expired = (wait_q == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q != VALID) begin
                wait_q <= '0;
            end else if (!ready_i) begin
                wait_q <= wait_q + 8'd1;
            end
            // Flag the DONE cycle that follows an abandoned wait.
            timeout_q <= (state_q == VALID) && !ready_i && wait_expired;
        end
    end

    assign timeout_o = timeout_q;
`else
    // Without the limit VALID waits indefinitely; the parameter only feeds a
    // constant sink so both builds share one parameter list.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
    assign wait_expired       = 1'b0;
    assign timeout_o          = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Outputs: registers or decodes of the registered state only
    // -----------------------------------------------------------------------
    assign state_o    = state_q;
    assign busy_o     = (state_q != IDLE);
    assign valid_o    = (state_q == VALID);
    assign done_o     = (state_q == DONE);
    assign data_o     = data_q;
    assign tx_count_o = count_q;

endmodule

// File: tb/tb_rx_transmitter_fsm.sv
// ---------------------------------------------------------------------------
// tb_rx_transmitter_fsm
//
// Self-checking bench for rx_transmitter_fsm. Inputs change on the falling
// edge and outputs are sampled on the next falling edge, half a cycle after
// the rising edge that consumed the inputs.
//
// The reference model tracks a transfer as a transaction: whether one is in
// flight, how many cycles old it is, and how it finished. Expected outputs
// are derived from those quantities each cycle.
//
// Build with RX_TX_TIMEOUT_EN defined to exercise the VALID wait limit with
// TIMEOUT_CYCLES = 4.
// ---------------------------------------------------------------------------
module tb_rx_transmitter_fsm;

    localparam int DATA_W = 5;
    localparam int CNT_W  = 8;
`ifdef RX_TX_TIMEOUT_EN
    localparam int TIMEOUT = 4;
    localparam bit TO_EN   = 1'b1;
`else
    localparam int TIMEOUT = 16;
    localparam bit TO_EN   = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              start_i;
    logic [DATA_W-1:0] data_i;
    logic              ready_i;
    logic              busy_o;
    logic              valid_o;
    logic [DATA_W-1:0] data_o;
    logic [1:0]        state_o;
    logic              done_o;
    logic              timeout_o;
    logic [CNT_W-1:0]  tx_count_o;

    rx_transmitter_fsm #(
        .DATA_W         (DATA_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .data_i     (data_i),
        .busy_o     (busy_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .state_o    (state_o),
        .done_o     (done_o),
        .timeout_o  (timeout_o),
        .tx_count_o (tx_count_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // -----------------------------------------------------------------------
    // Transaction-level reference model
    //   m_busy : a transfer is in flight
    //   m_age  : cycle index within the transfer (0 = the cycle after capture)
    //   m_fin  : 0 = still running, 1 = handshake completed, 2 = abandoned
    // -----------------------------------------------------------------------
    bit                m_busy  = 1'b0;
    int                m_age   = 0;
    int                m_fin   = 0;
    logic [DATA_W-1:0] m_word  = '0;
    logic [CNT_W-1:0]  m_count = '0;

    function automatic logic [1:0] m_state();
        if (!m_busy)     return 2'b00;
        if (m_fin != 0)  return 2'b11;
        if (m_age == 0)  return 2'b01;
        return 2'b10;
    endfunction

    // Packed view: {state, busy, valid, done, timeout, data, count}
    function automatic logic [18:0] model_vec();
        logic [1:0] s;
        s = m_state();
        return {s, s != 2'b00, s == 2'b10, s == 2'b11, m_fin == 2, m_word, m_count};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {state_o, busy_o, valid_o, done_o, timeout_o, data_o, tx_count_o};
    endfunction

    task automatic model_update(input bit r, input bit s, input logic [DATA_W-1:0] d,
                                input bit rd);
        if (r) begin
            m_busy = 1'b0; m_age = 0; m_fin = 0; m_word = '0; m_count = '0;
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1; m_word = d; m_age = 0; m_fin = 0;
            end
        end else if (m_fin != 0) begin
            m_busy = 1'b0; m_fin = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (rd) begin
            m_count++;
            m_fin = 1;
        end else if (TO_EN && m_age == TIMEOUT) begin
            m_fin = 2;
        end else begin
            m_age++;
        end
    endtask

    // Apply one cycle of inputs; returns at the following falling edge.
    task automatic drive(input bit r, input bit s, input logic [DATA_W-1:0] d, input bit rd);
        rst = r; start_i = s; data_i = d; ready_i = rd;
        @(posedge clk);
        model_update(r, s, d, rd);
        @(negedge clk);
    endtask

    task automatic drive_chk(input string name, input bit r, input bit s,
                             input logic [DATA_W-1:0] d, input bit rd);
        drive(r, s, d, rd);
        check(name, 32'(dut_vec()), 32'(model_vec()));
    endtask

    // -----------------------------------------------------------------------
    // Directed vector table
    // -----------------------------------------------------------------------
    typedef struct {
        bit                rst;
        bit                start;
        logic [DATA_W-1:0] data;
        bit                ready;
        logic [1:0]        st;
        bit                valid;
        bit                done;
        logic [DATA_W-1:0] dout;
        logic [CNT_W-1:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit s, input logic [DATA_W-1:0] d, input bit rd,
                       input logic [1:0] st, input bit v, input bit dn,
                       input logic [DATA_W-1:0] dout, input logic [CNT_W-1:0] cnt);
        vec_t e;
        e.rst = r; e.start = s; e.data = d; e.ready = rd;
        e.st = st; e.valid = v; e.done = dn; e.dout = dout; e.cnt = cnt;
        tbl.push_back(e);
    endtask

    initial begin
        int               vc;
        bit               seen_done;
        logic [CNT_W-1:0] base;

        rst = 1'b1; start_i = 1'b0; data_i = '0; ready_i = 1'b0;
        @(negedge clk);

        // reset + start together, basic send with ready tied high,
        // ignored start in LOAD/VALID/DONE, ignored ready in IDLE
        add(1, 1, 5'h1F, 1, 2'b00, 0, 0, 5'h00, 8'd0);
        add(0, 1, 5'h0A, 1, 2'b01, 0, 0, 5'h0A, 8'd0);
        add(0, 1, 5'h03, 1, 2'b10, 1, 0, 5'h0A, 8'd0);
        add(0, 1, 5'h03, 1, 2'b11, 0, 1, 5'h0A, 8'd1);
        add(0, 1, 5'h03, 1, 2'b00, 0, 0, 5'h0A, 8'd1);
        add(0, 0, 5'h03, 1, 2'b00, 0, 0, 5'h0A, 8'd1);
        add(0, 0, 5'h00, 1, 2'b00, 0, 0, 5'h0A, 8'd1);
        add(0, 1, 5'h15, 0, 2'b01, 0, 0, 5'h15, 8'd1);
        add(0, 1, 5'h03, 0, 2'b10, 1, 0, 5'h15, 8'd1);
        add(0, 1, 5'h03, 0, 2'b10, 1, 0, 5'h15, 8'd1);
        add(0, 0, 5'h00, 1, 2'b11, 0, 1, 5'h15, 8'd2);
        add(0, 0, 5'h00, 0, 2'b00, 0, 0, 5'h15, 8'd2);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].rst, tbl[i].start, tbl[i].data, tbl[i].ready);
            check($sformatf("vec%0d", i),
                  32'({state_o, busy_o, valid_o, done_o, timeout_o, data_o, tx_count_o}),
                  32'({tbl[i].st, tbl[i].st != 2'b00, tbl[i].valid, tbl[i].done,
                       1'b0, tbl[i].dout, tbl[i].cnt}));
        end

`ifndef RX_TX_TIMEOUT_EN
        // Backpressure: 7 refused cycles then acceptance -> 8 VALID cycles.
        base = tx_count_o;
        drive_chk("bp_load", 0, 1, 5'h1F, 0);
        vc = 0;
        for (int i = 0; i <= 8; i++) begin
            drive_chk($sformatf("bp_cyc%0d", i), 0, 0, 5'h00, i == 8);
            if (valid_o) begin
                vc++;
                check("bp_data_stable", 32'(data_o), 32'h1F);
            end
        end
        check("bp_valid_cycles", 32'(vc), 32'd8);
        check("bp_done", 32'(done_o), 32'd1);
        check("bp_count", 32'(tx_count_o), 32'(base + 8'd1));
        drive_chk("bp_idle", 0, 0, 5'h00, 0);
`endif

        // Reset held for 3 cycles mid-VALID discards the word, no done pulse.
        drive_chk("rst_load", 0, 1, 5'h15, 0);
        drive_chk("rst_valid", 0, 0, 5'h00, 0);
        check("rst_in_valid", 32'(valid_o), 32'd1);
        seen_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_chk($sformatf("rst_hold%0d", i), 1, 0, 5'h00, 0);
            if (i == 0) begin
                check("rst_all_zero", 32'(dut_vec()), 32'd0);
            end
            seen_done |= done_o;
        end
        drive(0, 0, 5'h00, 0);
        seen_done |= done_o;
        check("rst_no_done", 32'(seen_done), 32'd0);

`ifdef RX_TX_TIMEOUT_EN
        // Abandoned wait: 4 VALID cycles, then done+timeout together.
        base = tx_count_o;
        drive_chk("to_load", 0, 1, 5'h11, 0);
        vc = 0;
        for (int i = 0; i < 20 && !done_o; i++) begin
            drive_chk($sformatf("to_cyc%0d", i), 0, 0, 5'h00, 0);
            if (valid_o) vc++;
        end
        check("to_valid_cycles", 32'(vc), 32'd4);
        check("to_done", 32'(done_o), 32'd1);
        check("to_flag", 32'(timeout_o), 32'd1);
        check("to_count", 32'(tx_count_o), 32'(base));
        drive_chk("to_idle", 0, 0, 5'h00, 0);
        check("to_flag_clear", 32'(timeout_o), 32'd0);

        // Handshake in the expiry cycle wins.
        drive_chk("tw_load", 0, 1, 5'h12, 0);
        for (int i = 1; i <= 5; i++) begin
            drive_chk($sformatf("tw_cyc%0d", i), 0, 0, 5'h00, i == 5);
        end
        check("tw_done", 32'(done_o), 32'd1);
        check("tw_flag", 32'(timeout_o), 32'd0);
        check("tw_count", 32'(tx_count_o), 32'(base + 8'd1));
        drive_chk("tw_idle", 0, 0, 5'h00, 0);
`endif

        // Counter wrap: 256 back-to-back sends from a cleared count.
        drive_chk("wrap_rst", 1, 0, 5'h00, 0);
        for (int n = 0; n < 256; n++) begin
            drive_chk("wrap_start", 0, 1, 5'(n), 1);
            drive_chk("wrap_load", 0, 0, 5'h00, 1);
            drive_chk("wrap_valid", 0, 0, 5'h00, 1);
            drive_chk("wrap_done", 0, 0, 5'h00, 1);
            if (n == 254) check("wrap_255", 32'(tx_count_o), 32'd255);
        end
        check("wrap_zero", 32'(tx_count_o), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            drive_chk("rand", $urandom_range(0, 99) == 0, $urandom_range(0, 3) == 0,
                      5'($urandom), $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
